// File: rtl/input_repeat_engine_if.sv
// Key-level inputs and command-pulse outputs of the input repeat engine.
interface input_repeat_engine_if #(parameter int N_CH = 8);
  logic                tick_game;
  logic [N_CH-1:0]     raw;
  logic [2*N_CH-1:0]   mode;
  logic [N_CH-1:0]     cmd;
  logic [N_CH-1:0]     cmd_repeat;
  logic [N_CH-1:0]     held;

  modport master (output tick_game, raw, mode, input cmd, cmd_repeat, held);
  modport slave  (input tick_game, raw, mode, output cmd, cmd_repeat, held);
endinterface

// File: rtl/input_repeat_engine.sv
// N-channel key-to-command pulse engine with one-shot / DAS / fast repeat modes.
// Define INPUT_SOCD_EN to give channels 0/1 last-input-priority arbitration.
module input_repeat_lane #(
  parameter int TIMER_W     = 6,
  parameter int DAS_DELAY   = 10,
  parameter int DAS_SPEED   = 3,
  parameter int FAST_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key,
  input  logic [1:0] mode,
  output logic       cmd,
  output logic       cmd_repeat
);
  localparam logic [TIMER_W-1:0] DLY = TIMER_W'(DAS_DELAY);
  localparam logic [TIMER_W-1:0] FP  = TIMER_W'(FAST_PERIOD);
  localparam logic [TIMER_W-1:0] RLD = (DAS_SPEED > DAS_DELAY) ? '0 : TIMER_W'(DAS_DELAY - DAS_SPEED);

  logic               prev;
  logic [1:0]         mode_q;
  logic [TIMER_W-1:0] timer, nxt, period, reload;

  assign nxt    = timer + TIMER_W'(1);
  assign period = mode[0] ? FP : DLY;
  assign reload = mode[0] ? '0 : RLD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= 1'b0;
      mode_q     <= 2'b00;
      timer      <= '0;
      cmd        <= 1'b0;
      cmd_repeat <= 1'b0;
    end else begin
      prev       <= key;
      mode_q     <= mode;
      cmd        <= 1'b0;
      cmd_repeat <= 1'b0;
      // a mode change while held swallows the cycle; the new mode counts from the next one
      if (!key || mode == 2'b00 || (prev && mode != mode_q)) begin
        timer <= '0;
      end else if (!prev) begin
        cmd   <= 1'b1;
        timer <= '0;
      end else if (mode[1] && tick) begin
        if (nxt == period) begin
          cmd        <= 1'b1;
          cmd_repeat <= 1'b1;
          timer      <= reload;
        end else begin
          timer <= nxt;
        end
      end
    end
  end
endmodule

module input_repeat_engine #(
  parameter int N_CH        = 8,
  parameter int TIMER_W     = 6,
  parameter int DAS_DELAY   = 10,
  parameter int DAS_SPEED   = 3,
  parameter int FAST_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input_repeat_engine_if.slave  bus
);
  logic [N_CH-1:0] held_q, key, cmd_v, rep_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) held_q <= '0;
    else     held_q <= bus.raw;
  end

`ifdef INPUT_SOCD_EN
  logic owner, owner_nxt;

  always_comb begin
    owner_nxt = owner;
    if (bus.raw[1] && !held_q[1])      owner_nxt = 1'b1;
    else if (bus.raw[0] && !held_q[0]) owner_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner <= 1'b0;
    else     owner <= owner_nxt;
  end

  // the loser looks released to its lane, so re-gaining ownership reads as a fresh press
  always_comb begin
    key = bus.raw;
    if (bus.raw[0] && bus.raw[1]) begin
      if (owner_nxt) key[0] = 1'b0;
      else           key[1] = 1'b0;
    end
  end
`else
  always_comb key = bus.raw;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    input_repeat_lane #(
      .TIMER_W(TIMER_W), .DAS_DELAY(DAS_DELAY),
      .DAS_SPEED(DAS_SPEED), .FAST_PERIOD(FAST_PERIOD)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .tick       (bus.tick_game),
      .key        (key[i]),
      .mode       (bus.mode[2*i +: 2]),
      .cmd        (cmd_v[i]),
      .cmd_repeat (rep_v[i])
    );
  end

  assign bus.cmd        = cmd_v;
  assign bus.cmd_repeat = rep_v;
  assign bus.held       = held_q;
endmodule

// File: tb/tb_input_repeat_engine.sv
// Directed and random checks of input_repeat_engine against a tick-count reference model.
module tb_input_repeat_engine;
  localparam int N  = 8;
  localparam int TW = 6;
  localparam int DD = 10;
  localparam int DS = 3;
  localparam int FP = 2;
  localparam int SE = (DS > DD) ? DD : DS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_repeat_engine_if #(.N_CH(N)) bus ();

  input_repeat_engine #(
    .N_CH(N), .TIMER_W(TW), .DAS_DELAY(DD), .DAS_SPEED(DS), .FAST_PERIOD(FP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pulses[N];
  int reps[N];

  // model: ticks counted since the (effective) press, never reloaded
  logic [N-1:0] m_prev, m_held, exp_cmd, exp_rep;
  int           m_mprev[N];
  int           cnt[N];
  logic         m_owner;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_rep(input int md, input int c);
    if (md == 2) return (c == DD) || (c > DD && ((c - DD) % SE) == 0);
    return (c % FP) == 0;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_held = '0; exp_cmd = '0; exp_rep = '0; m_owner = 1'b0;
    for (int i = 0; i < N; i++) begin m_mprev[i] = 0; cnt[i] = 0; end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin pulses[i] = 0; reps[i] = 0; end
  endtask

  task automatic model_cycle();
    logic [N-1:0] key, nc, nr;
    key = bus.raw;
`ifdef INPUT_SOCD_EN
    if (bus.raw[1] && !m_held[1])      m_owner = 1'b1;
    else if (bus.raw[0] && !m_held[0]) m_owner = 1'b0;
    if (bus.raw[0] && bus.raw[1]) key[m_owner ? 0 : 1] = 1'b0;
`endif
    nc = '0; nr = '0;
    for (int i = 0; i < N; i++) begin
      int md;
      md = int'(bus.mode[2*i +: 2]);
      if (!key[i] || md == 0 || (m_prev[i] && md != m_mprev[i])) cnt[i] = 0;
      else if (!m_prev[i]) begin nc[i] = 1'b1; cnt[i] = 0; end
      else if (md >= 2 && bus.tick_game) begin
        cnt[i]++;
        if (is_rep(md, cnt[i])) begin nc[i] = 1'b1; nr[i] = 1'b1; end
      end
      m_prev[i]  = key[i];
      m_mprev[i] = md;
    end
    exp_cmd = nc; exp_rep = nr; m_held = bus.raw;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    chk("cmd", int'(bus.cmd), int'(exp_cmd));
    chk("cmd_repeat", int'(bus.cmd_repeat), int'(exp_rep));
    chk("held", int'(bus.held), int'(m_held));
    for (int i = 0; i < N; i++) begin
      pulses[i] += int'(bus.cmd[i]);
      reps[i]   += int'(bus.cmd_repeat[i]);
    end
  endtask

  // tick on every 4th cycle, never on the first cycle of a run
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      bus.tick_game = ((k % 4) == 3);
      step();
    end
    bus.tick_game = 1'b0;
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    logic [2*N-1:0] v;
    v = bus.mode;
    v[2*ch +: 2] = m;
    bus.mode = v;
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_game = 1'b0;
    bus.raw  = '0;
    bus.mode = '0;
    model_reset();
    clr_counts();
    #3;
    chk("reset_cmd", int'(bus.cmd), 0);
    chk("reset_held", int'(bus.held), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    run(4);

    // one-shot: a single pulse across 100 ticks
    set_mode(2, 2'b01);
    run(2);
    clr_counts();
    bus.raw[2] = 1'b1;
    run(400);
    chk("oneshot_pulses", pulses[2], 1);
    chk("oneshot_reps", reps[2], 0);
    bus.raw[2] = 1'b0;
    run(2);

    // DAS: press + ticks 10,13,16,19
    set_mode(0, 2'b10);
    run(2);
    clr_counts();
    bus.raw[0] = 1'b1;
    run(76);
    chk("das_pulses", pulses[0], 5);
    chk("das_reps", reps[0], 4);
    bus.raw[0] = 1'b0;
    run(2);

    // fast: press + ticks 2,4,6, then release / re-press restarts
    set_mode(3, 2'b11);
    run(2);
    clr_counts();
    bus.raw[3] = 1'b1;
    run(28);
    chk("fast_pulses", pulses[3], 4);
    chk("fast_reps", reps[3], 3);
    bus.raw[3] = 1'b0;
    run(1);
    clr_counts();
    bus.raw[3] = 1'b1;
    run(8);
    chk("fast_repress_pulses", pulses[3], 2);
    bus.raw[3] = 1'b0;
    run(2);

    // enabling a held channel: no pulse, first repeat on 10th tick
    clr_counts();
    bus.raw[4] = 1'b1;
    run(8);
    chk("disabled_pulses", pulses[4], 0);
    set_mode(4, 2'b10);
    run(40);
    chk("enable_pulses", pulses[4], 1);
    chk("enable_reps", reps[4], 1);
    bus.raw[4] = 1'b0;
    run(2);

    // opposing pair 0/1
    set_mode(1, 2'b10);
    run(2);
    bus.raw[0] = 1'b1;
    run(12);
    clr_counts();
    bus.raw[1] = 1'b1;
    run(48);
`ifdef INPUT_SOCD_EN
    chk("socd_ch0_silent", pulses[0], 0);
`else
    chk("indep_ch0", pulses[0], 2);
`endif
    chk("pair_ch1", pulses[1], 2);
    clr_counts();
    bus.raw[1] = 1'b0;
    run(44);
`ifdef INPUT_SOCD_EN
    chk("socd_ch0_regain", pulses[0], 2);
`else
    chk("indep_ch0_cont", pulses[0], 4);
`endif
    bus.raw[0] = 1'b0;
    run(2);

    // reset mid-repeat with key held
    bus.raw[0] = 1'b1;
    run(48);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_cmd", int'(bus.cmd), 0);
    chk("midrst_rep", int'(bus.cmd_repeat), 0);
    chk("midrst_held", int'(bus.held), 0);
    model_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    clr_counts();
    run(44);
    chk("postrst_pulses", pulses[0], 2);
    chk("postrst_reps", reps[0], 1);

    // random traffic
    for (int i = 0; i < N; i++) set_mode(i, 2'($urandom_range(0, 3)));
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [N-1:0] r;
        r = bus.raw;
        r[$urandom_range(0, N-1)] ^= 1'b1;
        bus.raw = r;
      end
      if ($urandom_range(0, 59) == 0) set_mode($urandom_range(0, N-1), 2'($urandom_range(0, 3)));
      bus.tick_game = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
